// File: rtl/car_motion_if.sv
// Signal bundle between the call decoder / display side and one elevator car
// controller. The master side drives the calls and the timebase, and the slave
// side is the car controller.
interface car_motion_if #(
    parameter int N_FLOORS = 6
);
    logic                tick;
    logic [N_FLOORS-1:0] req;
    logic                hold_door;
    logic                estop;
    logic [N_FLOORS-1:0] cur_floor;
    logic [N_FLOORS-1:0] pending;
    logic                dir_up;
    logic                moving;
    logic                door_open;
    logic                arrive;

    modport master (
        output tick, req, hold_door, estop,
        input  cur_floor, pending, dir_up, moving, door_open, arrive
    );

    modport slave (
        input  tick, req, hold_door, estop,
        output cur_floor, pending, dir_up, moving, door_open, arrive
    );
endinterface

// File: rtl/car_motion_ctrl.sv
// Position and motion controller for one elevator car.
// Calls are latched into a pending bitmap and served in SCAN order. Travel
// time per floor and door dwell are counted on the shared tick timebase.
//
//  state     | meaning
//  ----------+-----------------------------------------------------------
//  IDLE      | parked with door closed; picks the next call or direction
//  MOVE_UP   | travelling up; floor advances every TRAVEL_TICKS ticks
//  MOVE_DOWN | travelling down; floor advances every TRAVEL_TICKS ticks
//  DOOR_OPEN | door open at cur_floor; closes after DOOR_TICKS idle ticks
module car_motion_ctrl #(
    parameter int N_FLOORS     = 6,
    parameter int TRAVEL_TICKS = 4,
    parameter int DOOR_TICKS   = 8,
    parameter int RESET_FLOOR  = 0
) (
    input logic         clk,
    input logic         reset,
    car_motion_if.slave bus
);
    typedef enum logic [1:0] {IDLE, MOVE_UP, MOVE_DOWN, DOOR_OPEN} state_t;

    localparam int MAX_TICKS = (TRAVEL_TICKS > DOOR_TICKS) ? TRAVEL_TICKS : DOOR_TICKS;
    localparam int TW        = $clog2(MAX_TICKS) + 1;

    localparam logic [TW-1:0]       TRAVEL_LAST = TW'(TRAVEL_TICKS - 1);
    localparam logic [TW-1:0]       DOOR_LAST   = TW'(DOOR_TICKS - 1);
    localparam logic [TW-1:0]       T_ONE       = TW'(1);
    localparam logic [N_FLOORS-1:0] F_ONE       = {{(N_FLOORS-1){1'b0}}, 1'b1};
    localparam logic [N_FLOORS-1:0] F_RESET     = F_ONE << RESET_FLOOR;

    state_t              state_q, state_d;
    logic [N_FLOORS-1:0] floor_q, floor_d;
    logic [N_FLOORS-1:0] pend_q, pend_d;
    logic                dir_up_q, dir_up_d;
    logic [TW-1:0]       travel_q, travel_d;
    logic [TW-1:0]       door_q, door_d;
    logic                arrive_q, arrive_d;

    logic [N_FLOORS-1:0] below_mask, above_mask;
    logic [N_FLOORS-1:0] floor_up, floor_down;
    logic [N_FLOORS-1:0] req_eff, served;
    logic                pend_above, pend_below;

    // Floor masks relative to the one-hot position; the position minus one
    // sets exactly the bits below it.
    always_comb begin
        below_mask = floor_q - F_ONE;
        above_mask = ~(below_mask | floor_q);
        floor_up   = floor_q << 1;
        floor_down = floor_q >> 1;
        pend_above = |(pend_q & above_mask);
        pend_below = |(pend_q & below_mask);
    end

    // Register update; estop freezing is handled in the next-state logic.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            floor_q  <= F_RESET;
            pend_q   <= '0;
            dir_up_q <= 1'b1;
            travel_q <= '0;
            door_q   <= '0;
            arrive_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            floor_q  <= floor_d;
            pend_q   <= pend_d;
            dir_up_q <= dir_up_d;
            travel_q <= travel_d;
            door_q   <= door_d;
            arrive_q <= arrive_d;
        end
    end

    // Next state, timers, position and pending bitmap.
    always_comb begin
        state_d  = state_q;
        floor_d  = floor_q;
        dir_up_d = dir_up_q;
        travel_d = travel_q;
        door_d   = door_q;
        arrive_d = 1'b0;
        served   = '0;
        req_eff  = bus.req;
        // A call at the floor where the car stands is answered by the door,
        // so it never enters the bitmap.
        if (state_q == IDLE || state_q == DOOR_OPEN) begin
            req_eff = bus.req & ~floor_q;
        end
        if (!bus.estop) begin
            unique case (state_q)
                IDLE: begin
                    travel_d = '0;
                    if (|((bus.req | pend_q) & floor_q)) begin
                        state_d = DOOR_OPEN;
                        door_d  = '0;
                        served  = floor_q;
                    end else if (dir_up_q && pend_above) begin
                        state_d = MOVE_UP;
                    end else if (!dir_up_q && pend_below) begin
                        state_d = MOVE_DOWN;
                    end else if (pend_above) begin
                        dir_up_d = 1'b1;
                        state_d  = MOVE_UP;
                    end else if (pend_below) begin
                        dir_up_d = 1'b0;
                        state_d  = MOVE_DOWN;
                    end
                end
                MOVE_UP: begin
                    if (bus.tick) begin
                        if (travel_q == TRAVEL_LAST) begin
                            travel_d = '0;
                            if (floor_q[N_FLOORS-1]) begin
                                state_d = IDLE;
                            end else begin
                                floor_d = floor_up;
                                if (|(pend_q & floor_up)) begin
                                    state_d  = DOOR_OPEN;
                                    door_d   = '0;
                                    served   = floor_up;
                                    arrive_d = 1'b1;
                                end else if (!(|(pend_q & above_mask & ~floor_up))) begin
                                    state_d = IDLE;
                                end
                            end
                        end else begin
                            travel_d = travel_q + T_ONE;
                        end
                    end
                end
                MOVE_DOWN: begin
                    if (bus.tick) begin
                        if (travel_q == TRAVEL_LAST) begin
                            travel_d = '0;
                            if (floor_q[0]) begin
                                state_d = IDLE;
                            end else begin
                                floor_d = floor_down;
                                if (|(pend_q & floor_down)) begin
                                    state_d  = DOOR_OPEN;
                                    door_d   = '0;
                                    served   = floor_down;
                                    arrive_d = 1'b1;
                                end else if (!(|(pend_q & below_mask & ~floor_down))) begin
                                    state_d = IDLE;
                                end
                            end
                        end else begin
                            travel_d = travel_q + T_ONE;
                        end
                    end
                end
                DOOR_OPEN: begin
                    if (bus.hold_door || |(bus.req & floor_q)) begin
                        door_d = '0;
                    end else if (bus.tick) begin
                        if (door_q == DOOR_LAST) begin
                            state_d = IDLE;
                            door_d  = '0;
                        end else begin
                            door_d = door_q + T_ONE;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
        pend_d = (pend_q | req_eff) & ~served;
    end

    assign bus.cur_floor = floor_q;
    assign bus.pending   = pend_q;
    assign bus.dir_up    = dir_up_q;
    assign bus.moving    = (state_q == MOVE_UP) || (state_q == MOVE_DOWN);
    assign bus.door_open = (state_q == DOOR_OPEN);
    assign bus.arrive    = arrive_q;
endmodule

// File: tb/tb_car_motion_ctrl.sv
// Bench for car_motion_ctrl (6 floors, 4 ticks per floor, 8 ticks door dwell).
// A floor-index reference model runs alongside the DUT and is compared every
// cycle; a vector table and a few directed sequences add fixed expectations.
module tb_car_motion_ctrl;
    localparam int NF = 6;
    localparam int TT = 4;
    localparam int DT = 8;
    localparam int M_IDLE = 0;
    localparam int M_MOVE = 1;
    localparam int M_DOOR = 2;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;
    logic mon_en;

    car_motion_if #(.N_FLOORS(NF)) bus ();

    car_motion_ctrl #(
        .N_FLOORS(NF), .TRAVEL_TICKS(TT), .DOOR_TICKS(DT), .RESET_FLOOR(0)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int         floor;
        logic [5:0] pend;
        logic       up;
        int         mode;
        int         cnt;
        logic       arr;
    } mst_t;

    mst_t m;

    function automatic logic any_above(int f, logic [5:0] p);
        for (int i = f + 1; i < NF; i++) if (p[i]) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic any_below(int f, logic [5:0] p);
        for (int i = 0; i < f; i++) if (p[i]) return 1'b1;
        return 1'b0;
    endfunction

    function automatic mst_t model_reset();
        mst_t r;
        r.floor = 0; r.pend = '0; r.up = 1'b1; r.mode = M_IDLE; r.cnt = 0; r.arr = 1'b0;
        return r;
    endfunction

    // One clock of the car, written in floors and modes rather than bit vectors.
    function automatic mst_t model_step(mst_t s, logic tk, logic [5:0] rq, logic hd, logic es);
        mst_t       n = s;
        logic [5:0] clr = '0;
        logic [5:0] rq_eff = rq;
        int         nf;
        if (s.mode != M_MOVE) rq_eff[s.floor] = 1'b0;
        n.arr = 1'b0;
        if (!es) begin
            if (s.mode == M_IDLE) begin
                n.cnt = 0;
                if (rq[s.floor] || s.pend[s.floor]) begin
                    n.mode = M_DOOR;
                    clr[s.floor] = 1'b1;
                end else if (s.up && any_above(s.floor, s.pend)) n.mode = M_MOVE;
                else if (!s.up && any_below(s.floor, s.pend)) n.mode = M_MOVE;
                else if (any_above(s.floor, s.pend)) begin n.up = 1'b1; n.mode = M_MOVE; end
                else if (any_below(s.floor, s.pend)) begin n.up = 1'b0; n.mode = M_MOVE; end
            end else if (s.mode == M_MOVE) begin
                if (tk) begin
                    if (s.cnt == TT - 1) begin
                        n.cnt = 0;
                        nf = s.up ? s.floor + 1 : s.floor - 1;
                        if (nf < 0 || nf >= NF) n.mode = M_IDLE;
                        else begin
                            n.floor = nf;
                            if (s.pend[nf]) begin
                                n.mode = M_DOOR; clr[nf] = 1'b1; n.arr = 1'b1;
                            end else if (!(s.up ? any_above(nf, s.pend) : any_below(nf, s.pend)))
                                n.mode = M_IDLE;
                        end
                    end else n.cnt = s.cnt + 1;
                end
            end else begin
                if (hd || rq[s.floor]) n.cnt = 0;
                else if (tk) begin
                    if (s.cnt == DT - 1) begin n.mode = M_IDLE; n.cnt = 0; end
                    else n.cnt = s.cnt + 1;
                end
            end
        end
        n.pend = (s.pend | rq_eff) & ~clr;
        return n;
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) m <= model_reset();
        else m <= model_step(m, bus.tick, bus.req, bus.hold_door, bus.estop);
    end

    function automatic logic [15:0] dut_vec();
        return {bus.cur_floor, bus.pending, bus.dir_up, bus.moving, bus.door_open, bus.arrive};
    endfunction

    function automatic logic [15:0] model_vec(mst_t s);
        logic [5:0] one = 6'd1;
        return {one << s.floor, s.pend, s.up, s.mode == M_MOVE, s.mode == M_DOOR, s.arr};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) check("model", 32'(dut_vec()), 32'(model_vec(m)));
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        bus.tick = 1'b1; bus.req = '0; bus.hold_door = 1'b0; bus.estop = 1'b0;
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
    endtask

    task automatic wait_door(input logic want, input int budget, input string name);
        int k = 0;
        while (bus.door_open !== want && k < budget) begin cyc(); k++; end
        if (bus.door_open !== want) check(name, 32'(bus.door_open), 32'(want));
    endtask

    typedef struct {
        logic       tick;
        logic [5:0] req;
        logic       hold;
        logic       estop;
        int         cycles;
        logic [15:0] exp;
    } vec_t;

    function automatic vec_t mk(logic tk, logic [5:0] rq, logic hd, logic es, int n,
                                logic [5:0] cur, logic [5:0] pd, logic up, logic mv,
                                logic dr, logic ar);
        vec_t v;
        v.tick = tk; v.req = rq; v.hold = hd; v.estop = es; v.cycles = n;
        v.exp = {cur, pd, up, mv, dr, ar};
        return v;
    endfunction

    vec_t vt[14];

    initial begin
        logic [5:0] arr_floor[2];
        logic       arr_dir[2];
        int         n_arr;
        int         last_c;
        logic [5:0] prev;

        n_checks = 0; n_fail = 0; mon_en = 1'b0;
        vt[0]  = mk(1, 6'b100000, 0, 0, 1,  6'b000001, 6'b100000, 1, 0, 0, 0);
        vt[1]  = mk(1, 6'b000000, 0, 0, 1,  6'b000001, 6'b100000, 1, 1, 0, 0);
        vt[2]  = mk(1, 6'b000000, 0, 0, 4,  6'b000010, 6'b100000, 1, 1, 0, 0);
        vt[3]  = mk(1, 6'b000000, 0, 0, 15, 6'b010000, 6'b100000, 1, 1, 0, 0);
        vt[4]  = mk(1, 6'b000000, 0, 0, 1,  6'b100000, 6'b000000, 1, 0, 1, 1);
        vt[5]  = mk(1, 6'b000000, 0, 0, 1,  6'b100000, 6'b000000, 1, 0, 1, 0);
        vt[6]  = mk(1, 6'b000000, 0, 0, 6,  6'b100000, 6'b000000, 1, 0, 1, 0);
        vt[7]  = mk(1, 6'b000000, 0, 0, 1,  6'b100000, 6'b000000, 1, 0, 0, 0);
        vt[8]  = mk(1, 6'b100000, 0, 0, 1,  6'b100000, 6'b000000, 1, 0, 1, 0);
        vt[9]  = mk(1, 6'b000000, 0, 0, 8,  6'b100000, 6'b000000, 1, 0, 0, 0);
        vt[10] = mk(1, 6'b000001, 0, 0, 1,  6'b100000, 6'b000001, 1, 0, 0, 0);
        vt[11] = mk(1, 6'b000000, 0, 0, 1,  6'b100000, 6'b000001, 0, 1, 0, 0);
        vt[12] = mk(0, 6'b000000, 0, 0, 5,  6'b100000, 6'b000001, 0, 1, 0, 0);
        vt[13] = mk(1, 6'b000000, 0, 1, 3,  6'b100000, 6'b000001, 0, 1, 0, 0);

        // Reset values, then reset asserted mid-move.
        do_reset();
        mon_en = 1'b1;
        check("reset_state", 32'(dut_vec()), 32'({6'b000001, 6'b000000, 4'b1000}));
        bus.req = 6'b100000; cyc(); bus.req = '0;
        repeat (6) cyc();
        check("premove", 32'(bus.moving), 32'd1);
        #3 reset = 1'b0;
        #1 check("async_reset", 32'(dut_vec()), 32'({6'b000001, 6'b000000, 4'b1000}));
        @(negedge clk);
        @(posedge clk); #1 reset = 1'b1;

        // Vector table: full trip to the top, top call at top, reverse, tick hold, estop.
        do_reset();
        foreach (vt[i]) begin
            bus.tick = vt[i].tick; bus.req = vt[i].req;
            bus.hold_door = vt[i].hold; bus.estop = vt[i].estop;
            cyc();
            bus.req = '0;
            repeat (vt[i].cycles - 1) cyc();
            check($sformatf("vec%0d", i), 32'(dut_vec()), 32'(vt[i].exp));
        end

        // Two calls on either side while parked at floor 2 heading up.
        do_reset();
        bus.req = 6'b000100; cyc(); bus.req = '0;
        wait_door(1'b1, 100, "reach_floor2");
        check("at_floor2", 32'(bus.cur_floor), 32'(6'b000100));
        wait_door(1'b0, 30, "close_floor2");
        bus.req = 6'b010001; cyc(); bus.req = '0;
        n_arr = 0;
        for (int c = 0; c < 150; c++) begin
            cyc();
            if (bus.arrive === 1'b1) begin
                if (n_arr < 2) begin arr_floor[n_arr] = bus.cur_floor; arr_dir[n_arr] = bus.dir_up; end
                n_arr++;
            end
        end
        check("scan_arrivals", 32'(n_arr), 32'd2);
        if (n_arr >= 2) begin
            check("scan_first", 32'(arr_floor[0]), 32'(6'b010000));
            check("scan_second", 32'(arr_floor[1]), 32'(6'b000001));
            check("scan_dir", 32'(arr_dir[1]), 32'd0);
        end

        // Estop at travel count 2, with a call arriving during the stop.
        do_reset();
        bus.req = 6'b001000; cyc(); bus.req = '0;
        cyc(); cyc(); cyc();
        bus.estop = 1'b1; bus.req = 6'b100000; cyc(); bus.req = '0;
        repeat (9) cyc();
        check("estop_floor", 32'(bus.cur_floor), 32'(6'b000001));
        check("estop_moving", 32'(bus.moving), 32'd1);
        check("estop_pending", 32'(bus.pending), 32'(6'b101000));
        bus.estop = 1'b0; cyc();
        check("estop_resume1", 32'(bus.cur_floor), 32'(6'b000001));
        cyc();
        check("estop_resume2", 32'(bus.cur_floor), 32'(6'b000010));

        // Door hold and a re-call at the open floor.
        do_reset();
        bus.req = 6'b000001; cyc(); bus.req = '0;
        check("door_here", 32'({bus.door_open, bus.pending}), 32'({1'b1, 6'b000000}));
        repeat (5) cyc();
        bus.hold_door = 1'b1; cyc(); bus.hold_door = 1'b0;
        repeat (7) cyc();
        check("hold_open", 32'(bus.door_open), 32'd1);
        bus.req = 6'b000001; cyc(); bus.req = '0;
        check("recall_open", 32'({bus.door_open, bus.pending}), 32'({1'b1, 6'b000000}));
        repeat (7) cyc();
        check("recall_still", 32'(bus.door_open), 32'd1);
        cyc();
        check("recall_close", 32'(bus.door_open), 32'd0);

        // Tick on one cycle in three: a floor every 12 cycles.
        do_reset();
        last_c = -1; prev = bus.cur_floor;
        for (int c = 0; c < 80; c++) begin
            bus.tick = (c % 3 == 0);
            bus.req = (c == 0) ? 6'b000100 : 6'b000000;
            cyc();
            if (bus.cur_floor !== prev) begin
                if (last_c >= 0) check("tick3_interval", 32'(c - last_c), 32'd12);
                last_c = c; prev = bus.cur_floor;
            end
        end
        check("tick3_floor", 32'(bus.cur_floor), 32'(6'b000100));

        // Random traffic against the reference model.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            bus.tick = ($urandom_range(0, 3) != 0);
            bus.req = ($urandom_range(0, 11) == 0) ? (6'd1 << $urandom_range(0, NF - 1)) : 6'd0;
            bus.hold_door = ($urandom_range(0, 19) == 0);
            bus.estop = ($urandom_range(0, 24) == 0);
            cyc();
        end
        bus.estop = 1'b0; bus.req = '0; bus.hold_door = 1'b0;
        repeat (2) cyc();

        mon_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
